if_instr_mem_pipe: RTL

//   Parametrised, writable instruction memory for the IF stage. Replaces the fixed

---
 rtl/if_instr_mem_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_instr_mem_pipe.sv
// Writable instruction memory for the IF stage with a READ_LAT-deep response pipe.
// Ports: fetch req (valid/ready/addr), stall/flush, rsp (valid/instr/fault), prog write.
module if_instr_mem_pipe #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0033
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_rsp_valid,
  output logic [31:0] o_instr,
  output logic [1:0]  o_fault,
  input  logic        i_prog_we,
  input  logic [31:0] i_prog_addr,
  input  logic [31:0] i_prog_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LS = READ_LAT - 1;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: NOP_INSTR};

  logic [READ_LAT-1:0] valid_q, valid_d;
  logic [31:0]         instr_q [READ_LAT];
  logic [31:0]         instr_d [READ_LAT];
  logic [1:0]          fault_q [READ_LAT];
  logic [1:0]          fault_d [READ_LAT];

  logic          misal, oor, accept;
  logic          wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign unused_bits = ^i_prog_addr[1:0];

  assign o_req_ready = i_rst_n & ~i_stall
                     & ~i_flush & ~i_prog_we;

  // Range checks use the full word index;
  // truncation happens only afterwards.
  always_comb begin
    misal   = |i_addr[1:0];
    oor     = {2'b00, i_addr[31:2]}
              >= 32'(DEPTH_WORDS);
    rd_idx  = i_addr[AW+1:2];
    rd_word = mem_q[rd_idx];
    accept  = i_req_valid & o_req_ready;
    wr_ok   = {2'b00, i_prog_addr[31:2]}
              < 32'(DEPTH_WORDS);
    wr_idx  = i_prog_addr[AW+1:2];
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (i_flush) begin
      valid_d = '0;
    end else if (!i_stall) begin
      valid_d[0] = accept;
      instr_d[0] = (misal | oor) ? NOP_INSTR
                                 : rd_word;
      fault_d[0] = {oor, misal};
      for (int i = 1; i < READ_LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        instr_d[i] = instr_q[i-1];
        fault_d[i] = fault_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        instr_q[i] <= NOP_INSTR;
        fault_q[i] <= 2'b00;
      end
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Program writes ignore stall/flush; the
  // array is never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_prog_we && wr_ok) begin
      mem_q[wr_idx] <= i_prog_data;
    end
  end

  // Stale stage data is masked to NOP when idle.
  assign o_rsp_valid = valid_q[LS];
  assign o_instr = valid_q[LS] ? instr_q[LS]
                               : NOP_INSTR;
  assign o_fault = valid_q[LS] ? fault_q[LS]
                               : 2'b00;

endmodule
